// File: rtl/des_round_sequencer_if.sv
// Request, result and DES-core signals of the round sequencer.
// The sequencer takes the slave side; its driver takes the master side.
interface des_round_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [55:0] in_key;
    logic [63:0] in_data;
    logic        abort;
    logic [3:0]  des_roundSel;
    logic        des_decrypt;
    logic [55:0] des_key;
    logic [63:0] des_desIn;
    logic [63:0] des_desOut;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [15:0] blk_cnt;

    modport master (
        output in_valid, in_decrypt, in_key, in_data, abort,
        output des_desOut, out_ready,
        input  in_ready, des_roundSel, des_decrypt, des_key,
        input  des_desIn, out_valid, out_data, busy, blk_cnt
    );

    modport slave (
        input  in_valid, in_decrypt, in_key, in_data, abort,
        input  des_desOut, out_ready,
        output in_ready, des_roundSel, des_decrypt, des_key,
        output des_desIn, out_valid, out_data, busy, blk_cnt
    );
endinterface

// File: rtl/des_round_sequencer.sv
// Steps an iterative DES core through its 16 rounds and hands the
// captured result out over a valid/ready pair.
module des_round_sequencer #(
    parameter int unsigned OUT_LAT = 1
) (
    input logic                  clk,
    input logic                  rst,
    des_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, WAIT, DONE} state_e;

    localparam logic [2:0] WLAST = 3'(OUT_LAT - 1);

    state_e      state_q;
    logic [3:0]  rnd_q;
    logic [2:0]  wcnt_q;
    logic        dec_q;
    logic [55:0] key_q;
    logic [63:0] data_q;
    logic [63:0] out_q;
    logic [15:0] blk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            wcnt_q  <= 3'd0;
            dec_q   <= 1'b0;
            key_q   <= 56'd0;
            data_q  <= 64'd0;
            out_q   <= 64'd0;
            blk_q   <= 16'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        dec_q   <= bus.in_decrypt;
                        key_q   <= bus.in_key;
                        data_q  <= bus.in_data;
                        rnd_q   <= 4'd0;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    if (bus.abort) begin
                        rnd_q   <= 4'd0;
                        state_q <= IDLE;
                    end else if (rnd_q == 4'd15) begin
                        wcnt_q  <= 3'd0;
                        state_q <= WAIT;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                WAIT: begin
                    // counter parks at 15 so the core keeps seeing round 15
                    if (bus.abort) begin
                        rnd_q   <= 4'd0;
                        state_q <= IDLE;
                    end else if (wcnt_q == WLAST) begin
                        out_q   <= bus.des_desOut;
                        rnd_q   <= 4'd0;
                        state_q <= DONE;
                    end else begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        blk_q   <= blk_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.des_roundSel = rnd_q;
    assign bus.des_decrypt  = dec_q;
    assign bus.des_key      = key_q;
    assign bus.des_desIn    = data_q;
    assign bus.out_data     = out_q;
    assign bus.blk_cnt      = blk_q;
endmodule
